scoreboard_controller: RTL and testbench
========================================

Name: scoreboard_controller

Overview:
- Game scoreboard: a start input launches a timed round; each point pulse adds the current level's value to the score.
- Level advances every HITS_PER_LEVEL hits, and a BCD countdown timer ends the round.
- Score (3 digits), timer (2 digits) and level (1 digit) drive six 7-segment displays; Done flags the end of the round.
- Sits between debounced push-button inputs and the display pins.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per timer second (≥1).
- GAME_TIME, 60, round length in seconds, 1..99.
- HITS_PER_LEVEL, 4, hits needed per level increment, 1..15.
- MAX_LEVEL, 9, level saturation value, 1..9.

Ports:
- clk in 1: rising-edge clock.
- rst in 1: synchronous, active-high reset.
- St in 1: start request, level-sensitive.
- Pt in 1: point/hit input, synchronous level; a hit is a 0→1 transition between consecutive clk samples.
- Done in 1→out 1: high while in DONE.
- seg7_points_2 out 7: score hundreds.
- seg7_points_1 out 7: score tens.
- seg7_points_0 out 7: score ones.
- seg7_timer_1 out 7: seconds tens.
- seg7_timer_0 out 7: seconds ones.
- seg7_level out 7: level digit.

Behaviour:
- Segment encoding: bit order {g,f,e,d,c,b,a}, bit0 = a, active-high. Digit patterns:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
- Outputs are combinational decodes of registered BCD state; no extra latency.
- Reset (rst=1 at posedge): state IDLE, score 000, timer GAME_TIME, level 1, hit counter 0, tick counter 0, Pt/St previous-sample regs 0, Done 0.
- FSM states:
  - IDLE: St=1 → PLAY. On entry to PLAY: clear score to 000, load timer = GAME_TIME, level 1, hit counter 0, tick counter 0.
  - PLAY, tick counter: increments each cycle; at TICKS_PER_SEC-1 it wraps to 0 and the BCD timer decrements by 1 (00→ no wrap).
  - PLAY, expiry: when a decrement makes the timer 00, go to DONE on that edge; Done is high from the next cycle.
  - PLAY, hit: a detected hit adds the current level (1..9) to the 3-digit BCD score, ones digit with carry ripple. Score saturates at 999.
  - PLAY, level-up: the hit also increments the hit counter. When the counter reaches HITS_PER_LEVEL it resets to 0 and level increments, saturating at MAX_LEVEL. The new level applies from the next hit.
  - DONE: all values frozen, Done=1. A rising edge of St (previous sample 0, current 1) → PLAY with the same entry initialisation. Holding St high never auto-restarts.
- Simultaneous events:
  - A hit on the same cycle as the final timer decrement is counted.
  - A hit and a level-up on the same cycle: the add uses the pre-increment level.
  - Hits in IDLE/DONE are ignored.
- Pt sampled only at clk; pulses shorter than one period may be missed. Sources must hold Pt ≥1 cycle high and ≥1 cycle low between hits.
- Reset mid-round returns to IDLE immediately, discarding score.

Optional Feature:
- Macro SEG_ACTIVE_LOW_EN.
- Defined: all six seg7 outputs are bitwise inverted (common-anode boards), including during reset.
- Undefined: active-high encoding as above.
- No other behaviour changes.

Decomposition:
- Package scoreboard_pkg:
  - state enum {IDLE, PLAY, DONE}
  - 4-bit BCD digit typedef
  - 7-bit segment constants for 0–9
- Sub-module seg7_decode: 4-bit BCD in, 7-bit segments out, honouring SEG_ACTIVE_LOW_EN. Values >9 output all segments off. Instantiated six times.
- Top holds the FSM, BCD score adder, BCD timer and tick counter.

Test Plan:
- Reset then idle (TICKS_PER_SEC=2, GAME_TIME=60, St=0) → score 000 (0111111 ×3), timer 60 (1111101/0111111), level 1 (0000110), Done 0.
- St=1, then 4 hits with Pt 1 cycle high / 2 cycles low → score 004, level 2; hits 5–8 → score 012, level 3.
- 28 hits spaced 3 cycles, GAME_TIME=99, TICKS_PER_SEC=100 → score 112, level 8, Done 0.
- Let timer run (TICKS_PER_SEC=2, GAME_TIME=3) → timer 03→02→01→00 every 2 cycles; Done=1 the cycle after 00; later hits leave score unchanged.
- In DONE with St held 1 → stays DONE; St 0 then 1 → PLAY, score 000, timer reloaded, level 1, Done 0.
- Saturation: MAX_LEVEL=9, HITS_PER_LEVEL=1, many hits → level stops at 9, score stops at 999. Assert rst mid-round → IDLE, score 000 on the next cycle.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard controller: FSM states, BCD digit
// type, segment patterns and the BCD arithmetic helpers used by the datapath.
package scoreboard_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  typedef logic [3:0] bcd_t;

  // Segment order {g,f,e,d,c,b,a}, bit0 = a, active-high.
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Adds a single BCD digit to a 3-digit BCD value; clamps at 999 on overflow.
  function automatic logic [11:0] bcd_add_sat(input logic [11:0] value, input bcd_t inc);
    logic [4:0] d0;
    logic [4:0] d1;
    logic [4:0] d2;
    d0 = {1'b0, value[3:0]} + {1'b0, inc};
    d1 = {1'b0, value[7:4]};
    d2 = {1'b0, value[11:8]};
    if (d0 > 5'd9) begin
      d0 = d0 - 5'd10;
      d1 = d1 + 5'd1;
    end
    if (d1 > 5'd9) begin
      d1 = d1 - 5'd10;
      d2 = d2 + 5'd1;
    end
    if (d2 > 5'd9) begin
      return 12'h999;
    end
    return {d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  // Decrements a 2-digit BCD value; 00 stays 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] value);
    if (value == 8'h00) begin
      return 8'h00;
    end
    if (value[3:0] == 4'd0) begin
      return {value[7:4] - 4'd1, 4'd9};
    end
    return {value[7:4], value[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/scoreboard_controller_seg7_decode.sv
// BCD digit to 7-segment decoder; non-decimal codes blank the digit.
// SEG_ACTIVE_LOW_EN inverts the output for common-anode displays.
module seg7_decode
  import scoreboard_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  logic [6:0] seg_high;

  always_comb begin
    seg_high = SEG_OFF;
    case (bcd)
      4'd0:    seg_high = SEG_0;
      4'd1:    seg_high = SEG_1;
      4'd2:    seg_high = SEG_2;
      4'd3:    seg_high = SEG_3;
      4'd4:    seg_high = SEG_4;
      4'd5:    seg_high = SEG_5;
      4'd6:    seg_high = SEG_6;
      4'd7:    seg_high = SEG_7;
      4'd8:    seg_high = SEG_8;
      4'd9:    seg_high = SEG_9;
      default: seg_high = SEG_OFF;
    endcase
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign seg = ~seg_high;
`else
  assign seg = seg_high;
`endif

endmodule

// File: rtl/scoreboard_controller.sv
// Timed-round game scoreboard: FSM, BCD score adder, BCD countdown and level logic.
// Display polarity is selected with SEG_ACTIVE_LOW_EN (see seg7_decode).
module scoreboard_controller
  import scoreboard_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC  = 50000000,
  parameter int unsigned GAME_TIME      = 60,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       St,
  input  logic       Pt,
  output logic       Done,
  output logic [6:0] seg7_points_2,
  output logic [6:0] seg7_points_1,
  output logic [6:0] seg7_points_0,
  output logic [6:0] seg7_timer_1,
  output logic [6:0] seg7_timer_0,
  output logic [6:0] seg7_level
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [7:0] GAME_BCD = {4'(GAME_TIME / 10), 4'(GAME_TIME % 10)};
  localparam logic [3:0] HITS_TARGET = 4'(HITS_PER_LEVEL);
  localparam bcd_t LEVEL_MAX = 4'(MAX_LEVEL);

  state_t        state_q, state_d;
  logic [11:0]   score_q, score_d;
  logic [7:0]    timer_q, timer_d;
  bcd_t          level_q, level_d;
  logic [3:0]    hits_q, hits_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          pt_prev_q, pt_prev_d;
  logic          st_prev_q, st_prev_d;
  logic          done_q, done_d;

  logic hit;
  logic start;
  logic [7:0] timer_dec;

  assign hit       = Pt & ~pt_prev_q;
  assign timer_dec = bcd_dec(timer_q);

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    timer_d   = timer_q;
    level_d   = level_q;
    hits_d    = hits_q;
    tick_d    = tick_q;
    pt_prev_d = Pt;
    st_prev_d = St;
    start     = 1'b0;

    case (state_q)
      IDLE: start = St;
      PLAY: begin
        // Add with the level held before this edge; a level-up only affects later hits.
        if (hit) begin
          score_d = bcd_add_sat(score_q, level_q);
          if (hits_q + 4'd1 >= HITS_TARGET) begin
            hits_d = 4'd0;
            if (level_q < LEVEL_MAX) begin
              level_d = level_q + 4'd1;
            end
          end else begin
            hits_d = hits_q + 4'd1;
          end
        end
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          timer_d = timer_dec;
          if (timer_dec == 8'h00) begin
            state_d = DONE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DONE: start = St & ~st_prev_q;
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = PLAY;
      score_d = 12'h000;
      timer_d = GAME_BCD;
      level_d = 4'd1;
      hits_d  = 4'd0;
      tick_d  = '0;
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      score_q   <= 12'h000;
      timer_q   <= GAME_BCD;
      level_q   <= 4'd1;
      hits_q    <= 4'd0;
      tick_q    <= '0;
      pt_prev_q <= 1'b0;
      st_prev_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      timer_q   <= timer_d;
      level_q   <= level_d;
      hits_q    <= hits_d;
      tick_q    <= tick_d;
      pt_prev_q <= pt_prev_d;
      st_prev_q <= st_prev_d;
      done_q    <= done_d;
    end
  end

  assign Done = done_q;

  // Digit order: score hundreds/tens/ones, timer tens/ones, level.
  bcd_t       digits [6];
  logic [6:0] segs   [6];

  assign digits[0] = score_q[11:8];
  assign digits[1] = score_q[7:4];
  assign digits[2] = score_q[3:0];
  assign digits[3] = timer_q[7:4];
  assign digits[4] = timer_q[3:0];
  assign digits[5] = level_q;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_dec
      seg7_decode u_dec (
        .bcd (digits[gi]),
        .seg (segs[gi])
      );
    end
  endgenerate

  assign seg7_points_2 = segs[0];
  assign seg7_points_1 = segs[1];
  assign seg7_points_0 = segs[2];
  assign seg7_timer_1  = segs[3];
  assign seg7_timer_0  = segs[4];
  assign seg7_level    = segs[5];

endmodule

// File: tb/tb_scoreboard_controller.sv
// Directed bench: four scoreboard instances with different parameters, each
// exercised by its own hand-computed scenario.
module tb_scoreboard_controller;

  logic clk = 1'b0;
  logic rst;
  logic st [4];
  logic pt [4];
  logic done [4];
  logic [41:0] disp [4];
  logic [6:0] p2 [4], p1 [4], p0 [4], t1 [4], t0 [4], lv [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  scoreboard_controller #(.TICKS_PER_SEC(2), .GAME_TIME(60), .HITS_PER_LEVEL(4), .MAX_LEVEL(9)) u_a (
    .clk(clk), .rst(rst), .St(st[0]), .Pt(pt[0]), .Done(done[0]),
    .seg7_points_2(p2[0]), .seg7_points_1(p1[0]), .seg7_points_0(p0[0]),
    .seg7_timer_1(t1[0]), .seg7_timer_0(t0[0]), .seg7_level(lv[0]));

  scoreboard_controller #(.TICKS_PER_SEC(100), .GAME_TIME(99), .HITS_PER_LEVEL(4), .MAX_LEVEL(9)) u_b (
    .clk(clk), .rst(rst), .St(st[1]), .Pt(pt[1]), .Done(done[1]),
    .seg7_points_2(p2[1]), .seg7_points_1(p1[1]), .seg7_points_0(p0[1]),
    .seg7_timer_1(t1[1]), .seg7_timer_0(t0[1]), .seg7_level(lv[1]));

  scoreboard_controller #(.TICKS_PER_SEC(2), .GAME_TIME(3), .HITS_PER_LEVEL(4), .MAX_LEVEL(9)) u_c (
    .clk(clk), .rst(rst), .St(st[2]), .Pt(pt[2]), .Done(done[2]),
    .seg7_points_2(p2[2]), .seg7_points_1(p1[2]), .seg7_points_0(p0[2]),
    .seg7_timer_1(t1[2]), .seg7_timer_0(t0[2]), .seg7_level(lv[2]));

  scoreboard_controller #(.TICKS_PER_SEC(1000), .GAME_TIME(99), .HITS_PER_LEVEL(1), .MAX_LEVEL(9)) u_d (
    .clk(clk), .rst(rst), .St(st[3]), .Pt(pt[3]), .Done(done[3]),
    .seg7_points_2(p2[3]), .seg7_points_1(p1[3]), .seg7_points_0(p0[3]),
    .seg7_timer_1(t1[3]), .seg7_timer_0(t0[3]), .seg7_level(lv[3]));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_disp
      assign disp[gi] = {p2[gi], p1[gi], p0[gi], t1[gi], t0[gi], lv[gi]};
    end
  endgenerate

  function automatic logic [6:0] seg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b0111111;
      1: s = 7'b0000110;
      2: s = 7'b1011011;
      3: s = 7'b1001111;
      4: s = 7'b1100110;
      5: s = 7'b1101101;
      6: s = 7'b1111101;
      7: s = 7'b0000111;
      8: s = 7'b1111111;
      9: s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
`ifdef SEG_ACTIVE_LOW_EN
    s = ~s;
`endif
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic check_disp(input string tag, input int u, input int score, input int tmr, input int lvl);
    logic [41:0] exp;
    exp = {seg(score / 100), seg((score / 10) % 10), seg(score % 10),
           seg(tmr / 10), seg(tmr % 10), seg(lvl)};
    check(tag, 64'(disp[u]), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One hit: Pt high for one cycle, then low for two.
  task automatic hit(input int u);
    pt[u] = 1'b1;
    tick();
    pt[u] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      pt[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Instance A: reset state, idle hold, two levels of hits.
    check_disp("a_reset_disp", 0, 0, 60, 1);
    check("a_reset_done", 64'(done[0]), 64'd0);
    tick(); tick(); tick();
    check_disp("a_idle_disp", 0, 0, 60, 1);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    check_disp("a_entry_disp", 0, 0, 60, 1);
    for (int i = 0; i < 4; i++) hit(0);
    check_disp("a_4hits", 0, 4, 54, 2);
    for (int i = 0; i < 4; i++) hit(0);
    check_disp("a_8hits", 0, 12, 48, 3);
    check("a_play_done", 64'(done[0]), 64'd0);

    // Instance B: 28 hits across levels 1..7.
    st[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    for (int i = 0; i < 28; i++) hit(1);
    check_disp("b_28hits", 1, 112, 99, 8);
    check("b_done", 64'(done[1]), 64'd0);

    // Instance C: countdown to expiry, final-edge hit, DONE hold, restart.
    st[2] = 1'b1;
    tick();
    pt[2] = 1'b1;
    tick();
    pt[2] = 1'b0;
    check_disp("c_e1", 2, 1, 3, 1);
    tick();
    check_disp("c_e2", 2, 1, 2, 1);
    tick();
    tick();
    check_disp("c_e4", 2, 1, 1, 1);
    tick();
    check("c_e5_done", 64'(done[2]), 64'd0);
    pt[2] = 1'b1;
    tick();
    pt[2] = 1'b0;
    check_disp("c_expire_hit", 2, 2, 0, 1);
    check("c_expire_done", 64'(done[2]), 64'd1);
    tick();
    hit(2);
    hit(2);
    check_disp("c_done_frozen", 2, 2, 0, 1);
    check("c_st_held_done", 64'(done[2]), 64'd1);
    st[2] = 1'b0;
    tick();
    st[2] = 1'b1;
    tick();
    check_disp("c_restart_disp", 2, 0, 3, 1);
    check("c_restart_done", 64'(done[2]), 64'd0);
    st[2] = 1'b0;

    // Instance D: level and score saturation, then reset mid-round.
    st[3] = 1'b1;
    tick();
    st[3] = 1'b0;
    for (int i = 0; i < 9; i++) hit(3);
    check_disp("d_9hits", 3, 45, 99, 9);
    for (int i = 0; i < 121; i++) hit(3);
    check_disp("d_saturated", 3, 999, 99, 9);
    check("d_play_done", 64'(done[3]), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_disp("d_reset_disp", 3, 0, 99, 1);
    check("d_reset_done", 64'(done[3]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
